// File: rtl/sprite_pkg.sv
// Shared constants, state encoding and record types for the sprite line scheduler.
package sprite_pkg;

  localparam int unsigned DEF_NUM_SPRITES = 8;
  localparam int unsigned DEF_LINE_W      = 256;
  localparam int unsigned DEF_SPR_SIZE    = 16;

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned NUM_W = 6;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SCAN  = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef struct packed {
    logic             en;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [NUM_W-1:0] num;
  } attr_t;

  // Hit list entry: ROM sprite, line-buffer entry of column 0, ROM row.
  typedef struct packed {
    logic [NUM_W-1:0] num;
    logic [X_W-2:0]   xe;
    logic [2:0]       row;
  } hit_t;

endpackage

// File: rtl/sprite_attr_table.sv
// Sprite attribute register file: one write port, one combinational read port.
module sprite_attr_table
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = DEF_NUM_SPRITES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [$clog2(NUM_SPRITES)-1:0] wr_idx,
  input  attr_t                          wr_attr,
  input  logic [$clog2(NUM_SPRITES)-1:0] rd_idx,
  output attr_t                          rd_attr
);

  logic [NUM_SPRITES-1:0] en;
  logic [X_W-1:0]         x   [NUM_SPRITES];
  logic [Y_W-1:0]         y   [NUM_SPRITES];
  logic [NUM_W-1:0]       num [NUM_SPRITES];

  // Only the enables are reset; position/number are don't-care while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= '0;
    end else if (we) begin
      en[wr_idx] <= wr_attr.en;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      x[wr_idx]   <= wr_attr.x;
      y[wr_idx]   <= wr_attr.y;
      num[wr_idx] <= wr_attr.num;
    end
  end

  always_comb begin
    rd_attr     = '0;
    rd_attr.en  = en[rd_idx];
    rd_attr.x   = x[rd_idx];
    rd_attr.y   = y[rd_idx];
    rd_attr.num = num[rd_idx];
  end

endmodule

// File: rtl/sprite_line_scheduler.sv
// Builds one scanline of sprite pixels into a line-buffer bank: clear, scan attributes, draw hits.
module sprite_line_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int unsigned LINE_W      = DEF_LINE_W,
  parameter int unsigned SPR_SIZE    = DEF_SPR_SIZE
) (
  input  logic       i_Clk,
  input  logic       i_Rst_N,
  input  logic       i_Line_Start,
  input  logic [9:0] i_Next_Row,
  input  logic       i_Bank,
  input  logic       i_Attr_We,
  input  logic [2:0] i_Attr_Idx,
  input  logic       i_Attr_En,
  input  logic [9:0] i_Attr_X,
  input  logic [9:0] i_Attr_Y,
  input  logic [5:0] i_Attr_Num,
  output logic [5:0] o_Rom_Sprite,
  output logic [2:0] o_Rom_Row,
  output logic [2:0] o_Rom_Col,
  input  logic [1:0] i_Rom_Pixel,
  output logic       o_Lr_Write,
  output logic [8:0] o_Lr_Addr,
  output logic [1:0] o_Lr_Data,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Late
);

  localparam int unsigned IW = $clog2(NUM_SPRITES);
  localparam int unsigned CW = $clog2(LINE_W);

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic                   bank;
  logic [9:0]             row;
  logic [NUM_SPRITES-1:0] hit_mask;
  hit_t                   hits [NUM_SPRITES];
  logic                   pipe_valid;
  logic [9:0]             pipe_sum;

  attr_t                  wr_attr;
  attr_t                  rd_attr;
  logic [IW-1:0]          scan_idx;
  logic [9:0]             dy;
  logic                   hit;
  logic [IW-1:0]          cur;
  logic [NUM_SPRITES-1:0] cur_bit;
  hit_t                   cur_hit;
  logic                   issue;
  logic                   draw_wr;

  assign scan_idx = cnt[IW-1:0];

  always_comb begin
    wr_attr     = '0;
    wr_attr.en  = i_Attr_En;
    wr_attr.x   = i_Attr_X;
    wr_attr.y   = i_Attr_Y;
    wr_attr.num = i_Attr_Num;
  end

  sprite_attr_table #(
    .NUM_SPRITES(NUM_SPRITES)
  ) u_attr_table (
    .clk    (i_Clk),
    .rst_n  (i_Rst_N),
    .we     (i_Attr_We),
    .wr_idx (i_Attr_Idx),
    .wr_attr(wr_attr),
    .rd_idx (scan_idx),
    .rd_attr(rd_attr)
  );

  // Unsigned wrap makes rows above the sprite's top look huge, so one compare covers both edges.
  assign dy  = row - rd_attr.y;
  assign hit = rd_attr.en && (dy < 10'(SPR_SIZE));

  // Highest pending hit is drawn first so the lowest index lands last and wins.
  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (hit_mask[i]) cur = IW'(i);
    end
  end

  assign cur_bit = NUM_SPRITES'(1) << cur;
  assign cur_hit = hits[cur];
  assign issue   = (state == S_DRAW) && (cnt < CW'(8));

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bank       <= 1'b0;
      row        <= '0;
      hit_mask   <= '0;
      pipe_valid <= 1'b0;
      pipe_sum   <= '0;
    end else begin
      pipe_valid <= issue;
      pipe_sum   <= {1'b0, cur_hit.xe} + {7'b0, cnt[2:0]};
      if (i_Line_Start) begin
        state      <= S_CLEAR;
        cnt        <= '0;
        bank       <= i_Bank;
        row        <= i_Next_Row;
        hit_mask   <= '0;
        pipe_valid <= 1'b0;
      end else begin
        case (state)
          S_CLEAR: begin
            if (cnt == CW'(LINE_W - 1)) begin
              state <= S_SCAN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SCAN: begin
            if (hit) hit_mask[scan_idx] <= 1'b1;
            if (cnt == CW'(NUM_SPRITES - 1)) begin
              cnt   <= '0;
              state <= (hit || (hit_mask != '0)) ? S_DRAW : S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DRAW: begin
            if (cnt == CW'(8)) begin
              hit_mask <= hit_mask & ~cur_bit;
              cnt      <= '0;
              if ((hit_mask & ~cur_bit) == '0) state <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if ((state == S_SCAN) && hit && !i_Line_Start) begin
      hits[scan_idx] <= '{num: rd_attr.num, xe: rd_attr.x[9:1], row: dy[3:1]};
    end
  end

  assign draw_wr = (state == S_DRAW) && pipe_valid && (i_Rom_Pixel != 2'b00) &&
                   (pipe_sum < 10'(LINE_W));

  always_comb begin
    o_Rom_Sprite = '0;
    o_Rom_Row    = '0;
    o_Rom_Col    = '0;
    o_Lr_Write   = 1'b0;
    o_Lr_Addr    = '0;
    o_Lr_Data    = '0;
    if (issue) begin
      o_Rom_Sprite = cur_hit.num;
      o_Rom_Row    = cur_hit.row;
      o_Rom_Col    = cnt[2:0];
    end
    if (state == S_CLEAR) begin
      o_Lr_Write = 1'b1;
      o_Lr_Addr  = {bank, cnt[7:0]};
    end else if (draw_wr) begin
      o_Lr_Write = 1'b1;
      o_Lr_Addr  = {bank, pipe_sum[7:0]};
      o_Lr_Data  = i_Rom_Pixel;
    end
  end

  assign o_Busy = (state != S_IDLE);
  assign o_Done = (state == S_DONE);
  assign o_Late = i_Line_Start && o_Busy;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench: directed and random scanlines against a per-pixel reference of the line.
module tb_sprite_line_scheduler;

  logic       clk = 1'b0;
  logic       i_Rst_N = 1'b1;
  logic       i_Line_Start = 1'b0;
  logic [9:0] i_Next_Row = '0;
  logic       i_Bank = 1'b0;
  logic       i_Attr_We = 1'b0;
  logic [2:0] i_Attr_Idx = '0;
  logic       i_Attr_En = 1'b0;
  logic [9:0] i_Attr_X = '0;
  logic [9:0] i_Attr_Y = '0;
  logic [5:0] i_Attr_Num = '0;
  logic [1:0] i_Rom_Pixel = '0;
  logic [5:0] o_Rom_Sprite;
  logic [2:0] o_Rom_Row;
  logic [2:0] o_Rom_Col;
  logic       o_Lr_Write;
  logic [8:0] o_Lr_Addr;
  logic [1:0] o_Lr_Data;
  logic       o_Busy;
  logic       o_Done;
  logic       o_Late;

  int checks = 0;
  int errors = 0;

  sprite_line_scheduler #(.NUM_SPRITES(8), .LINE_W(256), .SPR_SIZE(16)) dut (
    .i_Clk(clk), .i_Rst_N(i_Rst_N), .i_Line_Start(i_Line_Start), .i_Next_Row(i_Next_Row),
    .i_Bank(i_Bank), .i_Attr_We(i_Attr_We), .i_Attr_Idx(i_Attr_Idx), .i_Attr_En(i_Attr_En),
    .i_Attr_X(i_Attr_X), .i_Attr_Y(i_Attr_Y), .i_Attr_Num(i_Attr_Num),
    .o_Rom_Sprite(o_Rom_Sprite), .o_Rom_Row(o_Rom_Row), .o_Rom_Col(o_Rom_Col),
    .i_Rom_Pixel(i_Rom_Pixel), .o_Lr_Write(o_Lr_Write), .o_Lr_Addr(o_Lr_Addr),
    .o_Lr_Data(o_Lr_Data), .o_Busy(o_Busy), .o_Done(o_Done), .o_Late(o_Late)
  );

  always #5 clk = ~clk;

  // Sprites numbered 32 and up are fully opaque; lower ones have transparent pixels.
  function automatic logic [1:0] rom_fn(input int s, input int r, input int c);
    if (s >= 32) return 2'(1 + ((s + r * 3 + c * 5) % 3));
    return 2'((s * 7 + r * 3 + c * 5) % 4);
  endfunction

  logic [1:0] ram [512];
  always @(posedge clk) i_Rom_Pixel <= rom_fn(int'(o_Rom_Sprite), int'(o_Rom_Row), int'(o_Rom_Col));
  always @(posedge clk) if (o_Lr_Write) ram[o_Lr_Addr] <= o_Lr_Data;

  logic mon_en = 1'b0;
  logic cur_bank = 1'b0;
  int   viol = 0;
  int   done_cnt = 0;
  always @(negedge clk) begin
    if (o_Done) done_cnt <= done_cnt + 1;
    if (mon_en) begin
      if (o_Lr_Write && (o_Lr_Addr[8] !== cur_bank)) viol <= viol + 1;
      else if (!o_Busy && ({o_Rom_Sprite, o_Rom_Row, o_Rom_Col, o_Lr_Write} != '0)) viol <= viol + 1;
    end
  end

  logic       m_en  [8];
  logic [9:0] m_x   [8];
  logic [9:0] m_y   [8];
  logic [5:0] m_num [8];
  logic [1:0] exp_line [256];
  logic [1:0] other_snap [256];
  int         exp_hits;
  int         viol_base;
  int         cyc;
  logic       line_bank;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_attr(input int idx, input logic en, input logic [9:0] x,
                            input logic [9:0] y, input logic [5:0] num);
    i_Attr_We = 1'b1; i_Attr_Idx = 3'(idx); i_Attr_En = en;
    i_Attr_X = x; i_Attr_Y = y; i_Attr_Num = num;
    m_en[idx] = en; m_x[idx] = x; m_y[idx] = y; m_num[idx] = num;
    tick();
    i_Attr_We = 1'b0;
  endtask

  task automatic disable_all();
    for (int i = 0; i < 8; i++) write_attr(i, 1'b0, '0, '0, '0);
  endtask

  // Expected line: cleared bank, then hits painted highest index first, clipped at the right edge.
  task automatic compute_exp(input logic [9:0] r);
    logic [9:0] dy;
    int e;
    logic [1:0] p;
    exp_hits = 0;
    for (int e2 = 0; e2 < 256; e2++) exp_line[e2] = 2'b00;
    for (int i = 7; i >= 0; i--) begin
      dy = r - m_y[i];
      if (m_en[i] && dy < 10'd16) begin
        exp_hits++;
        for (int c = 0; c < 8; c++) begin
          e = int'(m_x[i] >> 1) + c;
          p = rom_fn(int'(m_num[i]), int'(dy >> 1), c);
          if (e < 256 && p != 2'b00) exp_line[e] = p;
        end
      end
    end
  endtask

  task automatic start_line(input string tag, input logic [9:0] r, input logic b, input logic late);
    logic [8:0] a;
    compute_exp(r);
    for (int e = 0; e < 256; e++) begin
      a = {~b, 8'(e)};
      other_snap[e] = ram[a];
    end
    i_Next_Row = r; i_Bank = b; i_Line_Start = 1'b1;
    #1;
    check({tag, "_late"}, 64'(o_Late), 64'(late));
    tick();
    i_Line_Start = 1'b0;
    cur_bank = b;
    line_bank = b;
    mon_en = 1'b1;
    viol_base = viol;
    cyc = 1;
  endtask

  task automatic finish_line(input string tag, input bit mid_write, input bit chk_other);
    int done_cyc = 0;
    int mism = 0;
    int omism = 0;
    logic [8:0] a;
    while (cyc < 1000 && done_cyc == 0) begin
      if (o_Done) done_cyc = cyc;
      else begin
        if (mid_write && exp_hits >= 2 && cyc == 280) begin
          i_Attr_We = 1'b1; i_Attr_Idx = 3'($urandom_range(0, 7)); i_Attr_En = 1'b1;
          i_Attr_X = 10'($urandom); i_Attr_Y = i_Next_Row; i_Attr_Num = 6'($urandom);
          m_en[i_Attr_Idx] = 1'b1; m_x[i_Attr_Idx] = i_Attr_X;
          m_y[i_Attr_Idx] = i_Attr_Y; m_num[i_Attr_Idx] = i_Attr_Num;
        end
        if (cyc == 281) i_Attr_We = 1'b0;
        tick();
        cyc++;
      end
    end
    i_Attr_We = 1'b0;
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(265 + 9 * exp_hits));
    tick();
    check({tag, "_idle_after"}, {62'b0, o_Busy, o_Done}, 64'b0);
    for (int e = 0; e < 256; e++) begin
      a = {line_bank, 8'(e)};
      if (ram[a] !== exp_line[e]) mism++;
      a = {~line_bank, 8'(e)};
      if (ram[a] !== other_snap[e]) omism++;
    end
    check({tag, "_bank_mismatches"}, 64'(mism), 64'(0));
    if (chk_other) check({tag, "_other_bank_changes"}, 64'(omism), 64'(0));
    check({tag, "_protocol_violations"}, 64'(viol - viol_base), 64'(0));
    mon_en = 1'b0;
  endtask

  initial begin
    int dbase;
    logic [9:0] r;
    for (int i = 0; i < 8; i++) begin
      m_en[i] = 1'b0; m_x[i] = '0; m_y[i] = '0; m_num[i] = '0;
    end
    #3 i_Rst_N = 1'b0;
    tick(); tick();
    check("reset_outputs",
          {o_Rom_Sprite, o_Rom_Row, o_Rom_Col, o_Lr_Write, o_Lr_Addr, o_Lr_Data, o_Busy, o_Done, o_Late},
          64'b0);
    #2 i_Rst_N = 1'b1;
    tick();

    // Single sprite, bank 1, ROM row 2.
    write_attr(0, 1'b1, 10'h080, 10'h080, 6'd5);
    start_line("basic", 10'h085, 1'b1, 1'b0);
    finish_line("basic", 1'b0, 1'b1);
    check("basic_e140", 64'(ram[9'h140]), 64'd1);
    check("basic_e143_transparent", 64'(ram[9'h143]), 64'd0);

    // Overlapping opaque sprites: lowest index wins.
    disable_all();
    write_attr(2, 1'b1, 10'h040, 10'h010, 6'd40);
    write_attr(5, 1'b1, 10'h040, 10'h010, 6'd50);
    start_line("overlap", 10'h013, 1'b0, 1'b0);
    finish_line("overlap", 1'b0, 1'b1);
    check("overlap_winner", 64'(ram[9'h020]), 64'd2);

    // Right-edge clip without wrap.
    disable_all();
    write_attr(1, 1'b1, 10'h1FC, 10'h100, 6'd33);
    start_line("clip", 10'h100, 1'b0, 1'b0);
    finish_line("clip", 1'b0, 1'b1);
    check("clip_e254", 64'(ram[9'h0FE]), 64'd1);
    check("clip_no_wrap_e0", 64'(ram[9'h000]), 64'd0);

    // Vertical miss just below and just above the sprite.
    start_line("below", 10'h110, 1'b1, 1'b0);
    finish_line("below", 1'b0, 1'b1);
    start_line("above", 10'h0FF, 1'b0, 1'b0);
    finish_line("above", 1'b0, 1'b1);

    // Restart while clearing.
    write_attr(3, 1'b1, 10'h3F0, 10'h3F8, 6'd12);
    dbase = done_cnt;
    start_line("late_a", 10'h200, 1'b0, 1'b0);
    while (cyc < 100) begin tick(); cyc++; end
    mon_en = 1'b0;
    start_line("late_b", 10'h002, 1'b1, 1'b1);
    check("late_first_clear_write", {55'b0, o_Lr_Write, o_Lr_Addr}, {55'b0, 1'b1, 9'h100});
    finish_line("late_b", 1'b0, 1'b0);
    repeat (4) tick();
    check("late_single_done", 64'(done_cnt - dbase), 64'd1);

    // Reset in the middle of DRAW.
    disable_all();
    write_attr(0, 1'b1, 10'h020, 10'h050, 6'd44);
    start_line("rst_mid", 10'h052, 1'b0, 1'b0);
    while (cyc < 268) begin tick(); cyc++; end
    check("rst_mid_busy_before", 64'(o_Busy), 64'd1);
    mon_en = 1'b0;
    #2 i_Rst_N = 1'b0;
    #1;
    check("rst_mid_outputs",
          {o_Rom_Sprite, o_Rom_Row, o_Rom_Col, o_Lr_Write, o_Lr_Addr, o_Lr_Data, o_Busy, o_Done, o_Late},
          64'b0);
    tick();
    #2 i_Rst_N = 1'b1;
    for (int i = 0; i < 8; i++) m_en[i] = 1'b0;
    tick();
    start_line("after_rst", 10'h052, 1'b0, 1'b0);
    finish_line("after_rst", 1'b0, 1'b1);

    // Random lines with a mid-line attribute write that must not affect the current line.
    for (int n = 0; n < 8; n++) begin
      r = 10'($urandom);
      for (int i = 0; i < 8; i++)
        write_attr(i, ($urandom_range(0, 9) < 7), 10'($urandom), r - 10'($urandom_range(0, 20)),
                   6'($urandom));
      start_line($sformatf("rand%0d", n), r, 1'($urandom), 1'b0);
      finish_line($sformatf("rand%0d", n), 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
